ahbl_uart_rx: RTL and testbench

AHB-Lite slave UART receiver that complements the existing UART transmitter on the SoC peripheral bus. It oversamples the serial input at 16x baud, assembles 8N1 frames, buffers received bytes in a small FIFO and raises a level interrupt. The interrupt can drive a DMAC `PIRQ` line, so the DMAC can drain received bytes into data memory without CPU involvement.

---
 rtl/ahbl_uart_rx.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ahbl_uart_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver: 16x oversampled 8N1 (8E1 with UART_RX_PARITY_EN), receive FIFO, level IRQ.
// Optional feature macro: UART_RX_PARITY_EN.
module ahbl_uart_rx #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        rx,
  output logic        IRQ
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic        ap_valid;
  logic        ap_write;
  logic [1:0]  ap_sel;
  logic        rd_en;
  logic        wr_en;

  logic        en;
  logic        irqen;
  logic [3:0]  thresh;
  logic [15:0] bauddiv;

  logic        rx_m;
  logic        rx_s;
  logic [15:0] tcnt;
  logic        tick;

  logic [2:0]  state;
  logic [3:0]  sub;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        bad;
  logic        push_req;
  logic        samp;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [4:0]    count;
  logic          full;
  logic          ne;
  logic          pop;
  logic          push_ok;
  logic [7:0]    head;

  logic        ovr;
  logic        fe;
  logic        pe;
  logic        ovr_set;
  logic        fe_set;
  logic        st_wr;
  logic [3:0]  thr_eff;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16]};

  // Address phase capture; register access happens in the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_sel   <= 2'd0;
    end else begin
      ap_valid <= HSEL & HREADY & HTRANS[1];
      if (HSEL & HREADY & HTRANS[1]) begin
        ap_write <= HWRITE;
        ap_sel   <= HADDR[3:2];
      end
    end
  end

  assign rd_en = ap_valid & ~ap_write;
  assign wr_en = ap_valid &  ap_write;
  assign st_wr = wr_en & (ap_sel == 2'd1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en      <= 1'b0;
      irqen   <= 1'b0;
      thresh  <= 4'd0;
      bauddiv <= 16'd0;
    end else if (wr_en) begin
      if (ap_sel == 2'd2) begin
        en     <= HWDATA[0];
        irqen  <= HWDATA[1];
        thresh <= HWDATA[7:4];
      end
      if (ap_sel == 2'd3) bauddiv <= HWDATA[15:0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // >= lets a reduced BAUDDIV take effect at once instead of waiting for a 16-bit wrap.
  assign tick = en & (tcnt >= bauddiv);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)   tcnt <= 16'd0;
    else if (!en)   tcnt <= 16'd0;
    else if (tick)  tcnt <= 16'd0;
    else            tcnt <= tcnt + 16'd1;
  end

  assign samp = tick & (sub == 4'd15);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      sub      <= 4'd0;
      bitn     <= 3'd0;
      shreg    <= 8'd0;
      bad      <= 1'b0;
      push_req <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (!en) begin
        state <= S_IDLE;
      end else if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              state <= S_START;
              sub   <= 4'd0;
            end
          end
          S_START: begin
            sub <= sub + 4'd1;
            if (sub == 4'd7) begin
              if (!rx_s) begin
                state <= S_DATA;
                sub   <= 4'd0;
                bitn  <= 3'd0;
                bad   <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            sub <= sub + 4'd1;
            if (sub == 4'd15) begin
              shreg <= {rx_s, shreg[7:1]};
              bitn  <= bitn + 3'd1;
              if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            sub <= sub + 4'd1;
            if (sub == 4'd15) begin
              if (rx_s != ^shreg) bad <= 1'b1;
              state <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            sub <= sub + 4'd1;
            if (sub == 4'd15) begin
              if (rx_s & ~bad) push_req <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign fe_set = (state == S_STOP) & samp & ~rx_s;

  assign full    = (count == DEPTH_C);
  assign ne      = (count != 5'd0);
  assign pop     = rd_en & (ap_sel == 2'd0) & ne;
  assign push_ok = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;
  assign head    = ne ? mem[rptr] : 8'h00;

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= 5'd0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count + {4'd0, push_ok} - {4'd0, pop};
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovr <= 1'b0;
      fe  <= 1'b0;
    end else begin
      if (ovr_set)                 ovr <= 1'b1;
      else if (st_wr && HWDATA[2]) ovr <= 1'b0;
      if (fe_set)                  fe  <= 1'b1;
      else if (st_wr && HWDATA[3]) fe  <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pe_set;
  assign pe_set = (state == S_PARITY) & samp & (rx_s != ^shreg);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                pe <= 1'b0;
    else if (pe_set)             pe <= 1'b1;
    else if (st_wr && HWDATA[4]) pe <= 1'b0;
  end
`else
  assign pe = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (ap_sel)
        2'd0:    rdata = {24'd0, head};
        2'd1:    rdata = {19'd0, count, 3'd0, pe, fe, ovr, full, ne};
        2'd2:    rdata = {24'd0, thresh, 2'd0, irqen, en};
        default: rdata = {16'd0, bauddiv};
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign thr_eff   = (thresh == 4'd0) ? 4'd1 : thresh;
  assign IRQ       = irqen & (count >= {1'b0, thr_eff});

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Directed bench for ahbl_uart_rx: register table plus serial-frame sequences at BAUDDIV=3 (64 HCLK per bit).
module tb_ahbl_uart_rx;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        rx;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  ahbl_uart_rx #(.FIFO_DEPTH(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .rx(rx), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    wait_clks(1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a};
    wait_clks(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    wait_clks(1);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    wait_clks(1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a};
    wait_clks(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_clks);
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(64);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    wait_clks(64);
`endif
    rx = stop_val;
    wait_clks(stop_clks);
    rx = 1'b1;
    wait_clks(64);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 32'h0,         32'h0,    "rst_data"};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,         32'h0,    "rst_status"};
    vecs[2]  = '{1'b0, 4'h8, 32'h0,         32'h0,    "rst_ctrl"};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,         32'h0,    "rst_baud"};
    vecs[4]  = '{1'b1, 4'hC, 32'hFFFF_1234, 32'h0,    ""};
    vecs[5]  = '{1'b0, 4'hC, 32'h0,         32'h1234, "baud_rw"};
    vecs[6]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0,    ""};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,         32'hF3,   "ctrl_rw"};
    vecs[8]  = '{1'b1, 4'h4, 32'h0000_001F, 32'h0,    ""};
    vecs[9]  = '{1'b0, 4'h4, 32'h0,         32'h0,    "status_ro"};
    vecs[10] = '{1'b1, 4'h8, 32'h0,         32'h0,    ""};
    vecs[11] = '{1'b0, 4'h8, 32'h0,         32'h0,    "ctrl_clr"};

    HRESETn = 1'b0; HADDR = '0; HTRANS = '0; HSIZE = 3'd2; HWRITE = 1'b0;
    HREADY = 1'b1; HSEL = 1'b0; HWDATA = '0; rx = 1'b1;
    wait_clks(3);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_irq", {31'd0, IRQ}, 32'h0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'h1);
    HRESETn = 1'b1;
    wait_clks(2);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end
    end

    // Basic reception and pop
    bus_write(4'hC, 32'd3);
    bus_write(4'h8, 32'h1);
    send_byte(8'hA5, 1'b1, 64);
    read_check(4'h4, 32'h101, "a5_status");
    read_check(4'h0, 32'hA5,  "a5_data");
    read_check(4'h4, 32'h0,   "a5_status_after");

    // Glitch: three ticks low
    rx = 1'b0;
    wait_clks(12);
    rx = 1'b1;
    wait_clks(200);
    read_check(4'h4, 32'h0, "glitch_status");

    // Framing error
    send_byte(8'h3C, 1'b0, 40);
    read_check(4'h4, 32'h8, "fe_status");
    bus_write(4'h4, 32'h8);
    read_check(4'h4, 32'h0, "fe_cleared");

    // Overrun
    for (int b = 0; b < 9; b++) send_byte(8'(b), 1'b1, 64);
    read_check(4'h4, 32'h807, "ovr_status");
    for (int b = 0; b < 8; b++) read_check(4'h0, 32'(b), "ovr_data");
    read_check(4'h0, 32'h0, "empty_read");
    bus_write(4'h4, 32'h4);
    read_check(4'h4, 32'h0, "ovr_cleared");

    // Interrupt threshold 3
    bus_write(4'h8, 32'h33);
    send_byte(8'h01, 1'b1, 64);
    check("irq_b1", {31'd0, IRQ}, 32'h0);
    send_byte(8'h02, 1'b1, 64);
    check("irq_b2", {31'd0, IRQ}, 32'h0);
    send_byte(8'h03, 1'b1, 64);
    check("irq_b3", {31'd0, IRQ}, 32'h1);
    read_check(4'h0, 32'h01, "irq_pop1");
    wait_clks(1);
    check("irq_after_pop", {31'd0, IRQ}, 32'h0);
    read_check(4'h0, 32'h02, "irq_pop2");
    read_check(4'h0, 32'h03, "irq_pop3");

    // THRESH=0 behaves as 1; then reset mid-frame while IRQ is high
    bus_write(4'h8, 32'h03);
    send_byte(8'h11, 1'b1, 64);
    check("irq_thresh0", {31'd0, IRQ}, 32'h1);
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h5A >> i);
      wait_clks(64);
    end
    rx = 1'b1;
    wait_clks(32);
    #3 HRESETn = 1'b0;
    #1;
    check("midrst_irq", {31'd0, IRQ}, 32'h0);
    check("midrst_hrdata", HRDATA, 32'h0);
    wait_clks(3);
    HRESETn = 1'b1;
    wait_clks(2);
    read_check(4'h0, 32'h0, "midrst_data");
    read_check(4'h4, 32'h0, "midrst_status");
    read_check(4'h8, 32'h0, "midrst_ctrl");
    read_check(4'hC, 32'h0, "midrst_baud");
    bus_write(4'hC, 32'd3);
    bus_write(4'h8, 32'h1);
    send_byte(8'hC3, 1'b1, 64);
    read_check(4'h4, 32'h101, "post_rst_status");
    read_check(4'h0, 32'hC3,  "post_rst_data");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
